blink_mux_n_de2: RTL

BLINK_MUX_N_DE2 -- requirements
Module: blink_mux_n_de2

---
 rtl/blink_mux_n_de2.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/blink_mux_n_de2.sv
// blink_mux_n_de2: N_CH free-running blink dividers with a glitch-free
// output multiplexer. Channel k blinks at F_BASE_HZ*(k+1). A change on SW
// is synchronised, then the switch FSM waits for the current channel to be
// low, moves act_sel to the new channel, holds out low until that channel
// rises, and pulses sw_done.
//
//   state         | meaning
//   --------------+----------------------------------------------------
//   RUN           | out follows EN & phase[act_sel]; watch for new select
//   WAIT_CUR_LOW  | switch pending; wait for current channel to be low
//   WAIT_TGT_RISE | act_sel moved; out held low until new channel rises
module blink_mux_n_de2 #(
    parameter int N_CH      = 4,
    parameter int SEL_W     = 2,
    parameter int CLK_HZ    = 50_000_000,
    parameter int F_BASE_HZ = 1
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic [SEL_W-1:0] SW,
    input  logic             EN,
    output logic             out,
    output logic [SEL_W-1:0] act_sel,
    output logic             busy,
    output logic             sw_done
);

    typedef enum logic [1:0] {
        RUN           = 2'd0,
        WAIT_CUR_LOW  = 2'd1,
        WAIT_TGT_RISE = 2'd2
    } state_t;

    function automatic int half_period(input int k);
        return CLK_HZ / (2 * F_BASE_HZ * (k + 1));
    endfunction

    // Refuse to build a configuration whose dividers cannot exist.
    if (N_CH < 2 || N_CH > 8) begin : g_bad_nch
        $error("blink_mux_n_de2: N_CH must be in 2..8");
    end
    if (SEL_W != $clog2(N_CH)) begin : g_bad_selw
        $error("blink_mux_n_de2: SEL_W must equal clog2(N_CH)");
    end
    for (genvar g = 0; g < N_CH; g++) begin : g_chk
        if (half_period(g) < 1) begin : g_bad_half
            $error("blink_mux_n_de2: a channel half-period is below 1 cycle");
        end
    end

    logic [31:0]      cnt_q [N_CH];
    logic [31:0]      cnt_d [N_CH];
    logic [N_CH-1:0]  phase_q, phase_d;
    logic [N_CH-1:0]  wrap;
    logic [N_CH-1:0]  rise;

    logic [SEL_W-1:0] sync1_q, sync1_d;
    logic [SEL_W-1:0] sync2_q, sync2_d;
    logic [SEL_W-1:0] sel_c;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] act_sel_q, act_sel_d;
    logic [SEL_W-1:0] tgt_q, tgt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             out_q, out_d;

    // Dividers: count 0..H_k-1, toggle the phase on wrap; never gated.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        wrap    = '0;
        rise    = '0;
        for (int k = 0; k < N_CH; k++) begin
            wrap[k] = (cnt_q[k] == 32'(half_period(k) - 1));
            rise[k] = wrap[k] & ~phase_q[k];
            if (wrap[k]) begin
                cnt_d[k]   = '0;
                phase_d[k] = ~phase_q[k];
            end else begin
                cnt_d[k] = cnt_q[k] + 32'd1;
            end
        end
    end

    // Two-flop synchroniser for the switch inputs.
    always_comb begin
        sync1_d = SW;
        sync2_d = sync1_q;
    end

    // Selects beyond the last channel map onto the last channel.
    always_comb begin
        sel_c = sync2_q;
        if (int'(sync2_q) >= N_CH) begin
            sel_c = SEL_W'(N_CH - 1);
        end
    end

    // Switch FSM next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        act_sel_d = act_sel_q;
        tgt_d     = tgt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        out_d     = EN & phase_q[act_sel_q];
        case (state_q)
            RUN: begin
                if (sel_c != act_sel_q) begin
                    tgt_d   = sel_c;
                    busy_d  = 1'b1;
                    state_d = WAIT_CUR_LOW;
                end
            end
            WAIT_CUR_LOW: begin
                tgt_d = sel_c;
                if (sel_c == act_sel_q) begin
                    // Request withdrawn before anything moved.
                    busy_d  = 1'b0;
                    state_d = RUN;
                end else if (!phase_q[act_sel_q]) begin
                    act_sel_d = sel_c;
                    state_d   = WAIT_TGT_RISE;
                end
            end
            WAIT_TGT_RISE: begin
                // Hold low so the new channel starts with a full high phase.
                out_d = 1'b0;
                if (rise[act_sel_q]) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = RUN;
                end
            end
            default: begin
                busy_d  = 1'b0;
                out_d   = 1'b0;
                state_d = RUN;
            end
        endcase
    end

    // All state, with synchronous reset taking priority over everything.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            for (int k = 0; k < N_CH; k++) begin
                cnt_q[k] <= '0;
            end
            phase_q   <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            state_q   <= RUN;
            act_sel_q <= '0;
            tgt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            out_q     <= 1'b0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            phase_q   <= phase_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            act_sel_q <= act_sel_d;
            tgt_q     <= tgt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            out_q     <= out_d;
        end
    end

    assign out     = out_q;
    assign act_sel = act_sel_q;
    assign busy    = busy_q;
    assign sw_done = done_q;

endmodule
